// File: rtl/shift_pkg.sv
// Shared types and helpers for the runtime shift / AGC block.
// Holds the AGC state enum, the shift width, shift clamping and saturation limits.
package shift_pkg;

    localparam int SHIFT_W = 6;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        TRACK  = 2'd1,
        SETTLE = 2'd2
    } agc_state_e;

    function automatic logic signed [SHIFT_W-1:0] clamp_shift(
        input logic signed [SHIFT_W-1:0] s,
        input logic signed [SHIFT_W-1:0] lo,
        input logic signed [SHIFT_W-1:0] hi
    );
        if (s < lo) begin
            return lo;
        end
        if (s > hi) begin
            return hi;
        end
        return s;
    endfunction

    // Largest positive value of a dw-bit two's complement number
    function automatic logic signed [63:0] sat_hi(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    // Most negative value of a dw-bit two's complement number
    function automatic logic signed [63:0] sat_lo(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/var_shift_sat.sv
// Combinational runtime signed shifter: left shifts saturate, right shifts floor.
// Ports: din (sample), shift_amt (signed shift), dout (result), warning ([0] pos sat, [1] neg sat).
module var_shift_sat
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [SHIFT_W-1:0]    shift_amt,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            warning
);

    // Wide enough to hold the largest left shift without losing bits
    localparam int EW = DATA_WIDTH + (1 << (SHIFT_W - 1));
    localparam logic signed [EW-1:0] MAXV = EW'(sat_hi(DATA_WIDTH));
    localparam logic signed [EW-1:0] MINV = EW'(sat_lo(DATA_WIDTH));

    logic signed [DATA_WIDTH-1:0] sdin;
    logic signed [EW-1:0]         ext;
    logic signed [EW-1:0]         shl;
    logic [SHIFT_W-1:0]           ramt;

    always_comb begin
        sdin    = din;
        ext     = EW'(sdin);
        shl     = ext <<< shift_amt[SHIFT_W-2:0];
        ramt    = -shift_amt;
        dout    = din;
        warning = 2'b00;
        if (shift_amt[SHIFT_W-1]) begin
            dout = sdin >>> ramt;
        end else if (shl > MAXV) begin
            dout    = MAXV[DATA_WIDTH-1:0];
            warning = 2'b01;
        end else if (shl < MINV) begin
            dout    = MINV[DATA_WIDTH-1:0];
            warning = 2'b10;
        end else begin
            dout = shl[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/shift_agc.sv
// Runtime shift with saturation and window-based automatic gain control.
// Ports: clk, rst_n, en, manual_shift, din/din_valid in; dout/dout_valid/warning/shift_value/update out.
module shift_agc
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT_MIN  = -4,
    parameter int SHIFT_MAX  = 8,
    parameter int SHIFT_INIT = 0,
    parameter int WIN_LOG2   = 10,
    parameter int OVF_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [SHIFT_W-1:0]    manual_shift,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [1:0]            warning,
    output logic [SHIFT_W-1:0]    shift_value,
    output logic                  update
);

    localparam logic signed [SHIFT_W-1:0] S_MIN  = SHIFT_W'(SHIFT_MIN);
    localparam logic signed [SHIFT_W-1:0] S_MAX  = SHIFT_W'(SHIFT_MAX);
    localparam logic signed [SHIFT_W-1:0] S_INIT = SHIFT_W'(SHIFT_INIT);
    localparam logic [WIN_LOG2:0] O_TH = (WIN_LOG2 + 1)'(OVF_THRESH);
    // Half-scale thresholds +/- 2^(DW-2)
    localparam logic signed [DATA_WIDTH-1:0] HALF_P =
        DATA_WIDTH'(sat_hi(DATA_WIDTH - 1) + 64'sd1);
    localparam logic signed [DATA_WIDTH-1:0] HALF_N =
        DATA_WIDTH'(sat_lo(DATA_WIDTH - 1));

    agc_state_e            state_q, state_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic [WIN_LOG2-1:0]   win_q, win_d;
    logic [WIN_LOG2:0]     ovf_q, ovf_d;
    logic                  hr_q, hr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dv_q, dv_d;
    logic [1:0]            warn_q, warn_d;
    logic                  upd_q, upd_d;

    logic [DATA_WIDTH-1:0]        sh_dout;
    logic [1:0]                   sh_warn;
    logic signed [DATA_WIDTH-1:0] res_s;
    logic signed [SHIFT_W-1:0]    shift_s;
    logic signed [SHIFT_W-1:0]    man_shift;
    logic                         samp_ovf;
    logic                         samp_hr;
    logic [WIN_LOG2:0]            ovf_now;
    logic                         hr_now;
    logic                         win_last;

    var_shift_sat #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shift (
        .din      (din),
        .shift_amt(shift_q),
        .dout     (sh_dout),
        .warning  (sh_warn)
    );

    always_comb begin
        res_s     = sh_dout;
        shift_s   = shift_q;
        man_shift = clamp_shift(manual_shift, S_MIN, S_MAX);
        samp_ovf  = |sh_warn;
        samp_hr   = (res_s >= HALF_P) || (res_s <= HALF_N);
        // Statistics including the sample presented this cycle
        ovf_now   = ovf_q;
        if (samp_ovf && !(&ovf_q)) begin
            ovf_now = ovf_q + 1'b1;
        end
        hr_now    = hr_q | samp_hr;
        win_last  = &win_q;
    end

    always_comb begin
        dout_d = din_valid ? sh_dout : dout_q;
        warn_d = din_valid ? sh_warn : warn_q;
        dv_d   = din_valid;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        win_d   = win_q;
        ovf_d   = ovf_q;
        hr_d    = hr_q;
        upd_d   = 1'b0;
        unique case (state_q)
            MANUAL: begin
                shift_d = man_shift;
                win_d   = '0;
                ovf_d   = '0;
                hr_d    = 1'b0;
                if (en) begin
                    state_d = TRACK;
                    // A sample arriving with the enable rise opens the window
                    if (din_valid) begin
                        win_d = WIN_LOG2'(1);
                        ovf_d = (WIN_LOG2 + 1)'(samp_ovf);
                        hr_d  = samp_hr;
                    end
                end
            end
            TRACK: begin
                if (!en) begin
                    state_d = MANUAL;
                    win_d   = '0;
                    ovf_d   = '0;
                    hr_d    = 1'b0;
                end else if (din_valid) begin
                    win_d = win_q + 1'b1;
                    ovf_d = ovf_now;
                    hr_d  = hr_now;
                    if (win_last) begin
                        ovf_d = '0;
                        hr_d  = 1'b0;
                        if (ovf_now > O_TH && shift_s > S_MIN) begin
                            shift_d = shift_q - 1'b1;
                            upd_d   = 1'b1;
                            state_d = SETTLE;
                        end else if (!hr_now && shift_s < S_MAX) begin
                            shift_d = shift_q + 1'b1;
                            upd_d   = 1'b1;
                            state_d = SETTLE;
                        end
                    end
                end
            end
            SETTLE: begin
                if (!en) begin
                    state_d = MANUAL;
                    win_d   = '0;
                    ovf_d   = '0;
                    hr_d    = 1'b0;
                end else if (din_valid) begin
                    win_d = win_q + 1'b1;
                    if (win_last) begin
                        state_d = TRACK;
                    end
                end
            end
            default: begin
                state_d = MANUAL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MANUAL;
            shift_q <= S_INIT;
            win_q   <= '0;
            ovf_q   <= '0;
            hr_q    <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            warn_q  <= 2'b00;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            win_q   <= win_d;
            ovf_q   <= ovf_d;
            hr_q    <= hr_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            warn_q  <= warn_d;
            upd_q   <= upd_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dv_q;
    assign warning     = warn_q;
    assign shift_value = shift_q;
    assign update      = upd_q;

endmodule

// File: tb/tb_shift_agc.sv
// Scoreboard bench for shift_agc with an integer reference model.
// Stimulus pushes expected results; a monitor pops them as dout_valid appears.
module tb_shift_agc;

    localparam int DW    = 16;
    localparam int S_MIN = -4;
    localparam int S_MAX = 8;
    localparam int WLOG  = 4;
    localparam int WIN   = 1 << WLOG;
    localparam int OTH   = 4;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [5:0]  manual_shift;
    logic [15:0] din;
    logic        din_valid;
    logic [15:0] dout;
    logic        dout_valid;
    logic [1:0]  warning;
    logic [5:0]  shift_value;
    logic        update;

    shift_agc #(
        .DATA_WIDTH(DW),
        .SHIFT_MIN (S_MIN),
        .SHIFT_MAX (S_MAX),
        .SHIFT_INIT(0),
        .WIN_LOG2  (WLOG),
        .OVF_THRESH(OTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .manual_shift(manual_shift),
        .din         (din),
        .din_valid   (din_valid),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .warning     (warning),
        .shift_value (shift_value),
        .update      (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  w;
        logic [5:0]  s;
        logic        u;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int upd_seen = 0;

    // Reference model state: 0 manual, 1 tracking, 2 settling
    int m_state = 0;
    int m_shift = 0;
    int m_win = 0;
    int m_ovf = 0;
    int m_hr = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v);
        if (v < S_MIN) return S_MIN;
        if (v > S_MAX) return S_MAX;
        return v;
    endfunction

    // Shift by multiplication / floor division, then saturate
    function automatic void ref_out(input int s, input int sh,
                                    output int o, output int w);
        int d;
        w = 0;
        if (sh >= 0) begin
            o = s * (1 << sh);
            if (o > 32767) begin
                o = 32767;
                w = 1;
            end else if (o < -32768) begin
                o = -32768;
                w = 2;
            end
        end else begin
            d = 1 << (-sh);
            o = s / d;
            if (s < 0 && (s % d) != 0) o = o - 1;
        end
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_shift = 0;
        m_win   = 0;
        m_ovf   = 0;
        m_hr    = 0;
    endtask

    task automatic model_step(input logic e, input logic [5:0] ms,
                              input logic [15:0] d, input logic v);
        int o, w, hs, os, upd;
        exp_t x;
        ref_out(int'($signed(d)), m_shift, o, w);
        hs  = (o >= 16384 || o <= -16384) ? 1 : 0;
        os  = (w != 0) ? 1 : 0;
        upd = 0;
        if (m_state == 0) begin
            m_shift = clampi(int'($signed(ms)));
            m_win = 0;
            m_ovf = 0;
            m_hr  = 0;
            if (e) begin
                m_state = 1;
                if (v) begin
                    m_win = 1;
                    m_ovf = os;
                    m_hr  = hs;
                end
            end
        end else if (!e) begin
            m_state = 0;
            m_win = 0;
            m_ovf = 0;
            m_hr  = 0;
        end else if (v) begin
            m_win++;
            if (m_state == 1) begin
                if (os && m_ovf < 2 * WIN - 1) m_ovf++;
                if (hs) m_hr = 1;
                if (m_win == WIN) begin
                    if (m_ovf > OTH && m_shift > S_MIN) begin
                        m_shift--;
                        upd = 1;
                        m_state = 2;
                    end else if (!m_hr && m_shift < S_MAX) begin
                        m_shift++;
                        upd = 1;
                        m_state = 2;
                    end
                    m_win = 0;
                    m_ovf = 0;
                    m_hr  = 0;
                end
            end else if (m_win == WIN) begin
                m_state = 1;
                m_win = 0;
            end
        end
        if (v) begin
            x.d = 16'(o);
            x.w = 2'(w);
            x.s = 6'(m_shift);
            x.u = 1'(upd);
            q.push_back(x);
        end
    endtask

    task automatic drive(input logic e, input logic [5:0] ms,
                         input logic [15:0] d, input logic v);
        @(negedge clk);
        en = e;
        manual_shift = ms;
        din = d;
        din_valid = v;
        model_step(e, ms, d, v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        din_valid = 1'b0;
        manual_shift = 6'd0;
        din = 16'd0;
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_dout_valid", 32'(dout_valid), 32'h0);
        chk("rst_shift", 32'(shift_value), 32'h0);
        chk("rst_update", 32'(update), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (update) upd_seen++;
            if (dout_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_dout_valid", 32'(dout_valid), 32'h0);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("dout", 32'(dout), 32'(x.d));
                    chk("warning", 32'(warning), 32'(x.w));
                    chk("shift_value", 32'(shift_value), 32'(x.s));
                    chk("update", 32'(update), 32'(x.u));
                end
            end else begin
                chk("update_idle", 32'(update), 32'h0);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int u0;
        logic [15:0] rd;
        rst_n = 1'b0;
        en = 1'b0;
        manual_shift = 6'd0;
        din = 16'd0;
        din_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_dout", 32'(dout), 32'h0);
        chk("init_dout_valid", 32'(dout_valid), 32'h0);
        chk("init_shift", 32'(shift_value), 32'h0);
        chk("init_update", 32'(update), 32'h0);

        // Manual mode, shift 2
        drive(1'b0, 6'd2, 16'h0000, 1'b0);
        drive(1'b0, 6'd2, 16'h0100, 1'b1);
        drive(1'b0, 6'd2, 16'h4000, 1'b1);
        drive(1'b0, 6'd2, 16'hC000, 1'b1);
        // Manual mode, other shifts
        drive(1'b0, 6'h3F, 16'h0000, 1'b0);
        drive(1'b0, 6'h3F, 16'hFFFF, 1'b1);
        drive(1'b0, 6'd12, 16'h0000, 1'b0);
        drive(1'b0, 6'd12, 16'h0003, 1'b1);
        drive(1'b0, 6'h3C, 16'h8001, 1'b1);

        // AGC step down
        drive(1'b0, 6'd2, 16'h0000, 1'b0);
        drive(1'b0, 6'd2, 16'h0000, 1'b0);
        u0 = upd_seen;
        repeat (16 + 16 + 48) drive(1'b1, 6'd2, 16'h3000, 1'b1);
        drive(1'b1, 6'd2, 16'h0000, 1'b0);
        @(posedge clk);
        #2;
        chk("stepdown_shift", 32'(shift_value), 32'd1);
        chk("stepdown_updates", 32'(upd_seen - u0), 32'd1);

        // AGC step up to the half-scale limit
        drive(1'b0, 6'd0, 16'h0000, 1'b0);
        drive(1'b0, 6'd0, 16'h0000, 1'b0);
        u0 = upd_seen;
        repeat (240) drive(1'b1, 6'd0, 16'h0100, 1'b1);
        drive(1'b1, 6'd0, 16'h0000, 1'b0);
        @(posedge clk);
        #2;
        chk("stepup_shift", 32'(shift_value), 32'd6);
        chk("stepup_updates", 32'(upd_seen - u0), 32'd6);

        // Partial window discarded when en drops
        drive(1'b0, 6'd0, 16'h0000, 1'b0);
        drive(1'b0, 6'd0, 16'h0000, 1'b0);
        repeat (10) drive(1'b1, 6'd0, 16'h0100, 1'b1);
        drive(1'b0, 6'd0, 16'h0000, 1'b0);
        drive(1'b0, 6'd0, 16'h0100, 1'b1);
        u0 = upd_seen;
        repeat (15) drive(1'b1, 6'd0, 16'h0100, 1'b1);
        drive(1'b1, 6'd0, 16'h0000, 1'b0);
        @(posedge clk);
        #2;
        chk("reenable_no_update", 32'(upd_seen - u0), 32'd0);
        drive(1'b1, 6'd0, 16'h0100, 1'b1);
        drive(1'b1, 6'd0, 16'h0000, 1'b0);
        @(posedge clk);
        #2;
        chk("reenable_update", 32'(upd_seen - u0), 32'd1);

        // Valid toggling
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 6'd0, 16'h0200, 1'(i % 2));
        end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rd = 16'($urandom);
            rd = 16'($signed(rd) >>> $urandom_range(0, 14));
            drive(($urandom_range(0, 99) != 0), 6'($urandom), rd,
                  1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a window
        drive(1'b0, 6'd3, 16'h0000, 1'b0);
        drive(1'b0, 6'd3, 16'h0000, 1'b0);
        repeat (7) drive(1'b1, 6'd3, 16'h0100, 1'b1);
        do_reset();
        drive(1'b0, 6'd1, 16'h0000, 1'b0);
        drive(1'b0, 6'd1, 16'h1234, 1'b1);
        repeat (3) drive(1'b0, 6'd1, 16'h0000, 1'b0);
        @(posedge clk);
        #2;
        chk("queue_drain", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
